hood_mode_sequencer: RTL and testbench

//  Sequences the range-hood fan and its timed modes: takes one-shot mode requests from the menu/key layer,

---
 rtl/hood_pkg.sv | 37 +++
 rtl/sec_countdown.sv | 32 +++
 rtl/hood_mode_sequencer.sv | 175 +++++++++++++++++
 tb/tb_hood_mode_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// hood_pkg -- shared mode encodings, fan levels and hood state enum (rev 1.0)
`default_nettype none

package hood_pkg;

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_L1    = 3'd1;
  localparam logic [2:0] MODE_L2    = 3'd2;
  localparam logic [2:0] MODE_HURR  = 3'd3;
  localparam logic [2:0] MODE_CLEAN = 3'd4;

  localparam logic [1:0] FAN_OFF  = 2'd0;
  localparam logic [1:0] FAN_LOW  = 2'd1;
  localparam logic [1:0] FAN_MID  = 2'd2;
  localparam logic [1:0] FAN_HURR = 2'd3;

  // State codes deliberately equal the request mode codes.
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_L1    = 3'd1,
    ST_L2    = 3'd2,
    ST_HURR  = 3'd3,
    ST_CLEAN = 3'd4
  } hood_state_e;

  function automatic logic [1:0] fan_of(input hood_state_e s);
    case (s)
      ST_L1:   fan_of = FAN_LOW;
      ST_L2:   fan_of = FAN_MID;
      ST_HURR: fan_of = FAN_HURR;
      default: fan_of = FAN_OFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sec_countdown.sv
// sec_countdown -- 8-bit seconds down counter shared by the timed modes (rev 1.0)
`default_nettype none

module sec_countdown (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_tick,
  output logic [7:0] o_count,
  output logic       o_expire
);

  logic [7:0] r_count;

  // A load always wins over a tick arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_count  = r_count;
  assign o_expire = i_tick && !i_load && (r_count == 8'd1);

endmodule

`default_nettype wire

// File: rtl/hood_mode_sequencer.sv
// hood_mode_sequencer -- request arbiter, mode state register and usage accumulator (rev 1.0)
`default_nettype none

module hood_mode_sequencer
  import hood_pkg::*;
#(
  parameter int unsigned HURR_S   = 60,
  parameter int unsigned CLEAN_S  = 180,
  parameter int unsigned REMIND_S = 36000,
  parameter int unsigned USAGE_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_1hz,
  input  logic       i_power_on,
  input  logic       i_req_valid,
  input  logic [2:0] i_req_mode,
  output logic       o_req_accept,
  output logic       o_req_reject,
  output logic [1:0] o_fan_level,
  output logic       o_cleaning,
  output logic [7:0] o_time_left,
  output logic       o_hurr_avail,
  output logic       o_clean_reminder
);

  localparam logic [USAGE_W-1:0] c_USAGE_MAX = {USAGE_W{1'b1}};

  hood_state_e        r_state;
  logic [1:0]         r_fan_level;
  logic               r_cleaning;
  logic               r_accept;
  logic               r_reject;
  logic               r_off_pending;
  logic               r_hurr_avail;
  logic [USAGE_W-1:0] r_usage;
  logic               r_reminder;

  hood_state_e        w_next_state;
  logic               w_load;
  logic [7:0]         w_load_val;
  logic               w_accept;
  logic               w_reject;
  logic               w_set_off_pending;
  logic               w_use_hurr;
  logic               w_clean_done;
  logic               w_expire;
  logic [7:0]         w_count;
  logic [USAGE_W-1:0] w_usage_next;

  sec_countdown u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (i_tick_1hz),
    .o_count    (w_count),
    .o_expire   (w_expire)
  );

  // Priority: power loss, then timer expiry, then the pending request.
  always_comb begin
    w_next_state      = r_state;
    w_load            = 1'b0;
    w_load_val        = 8'd0;
    w_accept          = 1'b0;
    w_reject          = 1'b0;
    w_set_off_pending = 1'b0;
    w_use_hurr        = 1'b0;
    w_clean_done      = 1'b0;
    if (!i_power_on) begin
      w_next_state = ST_OFF;
      w_load       = 1'b1;
      w_reject     = i_req_valid;
    end else if (w_expire && (r_state == ST_HURR || r_state == ST_CLEAN)) begin
      w_reject = i_req_valid;
      if (r_state == ST_HURR) begin
        w_next_state = r_off_pending ? ST_OFF : ST_L2;
      end else begin
        w_next_state = ST_OFF;
        w_clean_done = 1'b1;
      end
    end else if (i_req_valid) begin
      case (r_state)
        ST_OFF, ST_L1, ST_L2: begin
          case (i_req_mode)
            MODE_OFF, MODE_L1, MODE_L2: begin
              w_accept     = 1'b1;
              w_next_state = hood_state_e'(i_req_mode);
            end
            MODE_HURR: begin
              if (r_hurr_avail) begin
                w_accept     = 1'b1;
                w_next_state = ST_HURR;
                w_load       = 1'b1;
                w_load_val   = 8'(HURR_S);
                w_use_hurr   = 1'b1;
              end else begin
                w_reject = 1'b1;
              end
            end
            MODE_CLEAN: begin
              w_accept     = 1'b1;
              w_next_state = ST_CLEAN;
              w_load       = 1'b1;
              w_load_val   = 8'(CLEAN_S);
            end
            default: w_reject = 1'b1;
          endcase
        end
        ST_HURR: begin
          if (i_req_mode == MODE_OFF) begin
            w_accept          = 1'b1;
            w_set_off_pending = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
        default: w_reject = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_usage_next = r_usage;
    if (w_clean_done) begin
      w_usage_next = '0;
    end else if (i_tick_1hz && (r_fan_level != FAN_OFF) && (r_usage != c_USAGE_MAX)) begin
      w_usage_next = r_usage + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_OFF;
      r_fan_level   <= FAN_OFF;
      r_cleaning    <= 1'b0;
      r_accept      <= 1'b0;
      r_reject      <= 1'b0;
      r_off_pending <= 1'b0;
      r_hurr_avail  <= 1'b1;
      r_usage       <= '0;
      r_reminder    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_fan_level <= fan_of(w_next_state);
      r_cleaning  <= (w_next_state == ST_CLEAN);
      r_accept    <= w_accept;
      r_reject    <= w_reject;
      if (!i_power_on || (w_next_state != ST_HURR)) begin
        r_off_pending <= 1'b0;
      end else if (w_set_off_pending) begin
        r_off_pending <= 1'b1;
      end
      if (!i_power_on) begin
        r_hurr_avail <= 1'b1;
      end else if (w_use_hurr) begin
        r_hurr_avail <= 1'b0;
      end
      r_usage    <= w_usage_next;
      r_reminder <= (w_usage_next >= USAGE_W'(REMIND_S));
    end
  end

  assign o_req_accept     = r_accept;
  assign o_req_reject     = r_reject;
  assign o_fan_level      = r_fan_level;
  assign o_cleaning       = r_cleaning;
  assign o_time_left      = w_count;
  assign o_hurr_avail     = r_hurr_avail;
  assign o_clean_reminder = r_reminder;

endmodule

`default_nettype wire

// File: tb/tb_hood_mode_sequencer.sv
// tb_hood_mode_sequencer -- directed vectors for the hood mode sequencer (rev 1.0)
`default_nettype none

module tb_hood_mode_sequencer;

  logic       clk;
  logic       rst_n;
  logic       i_tick_1hz;
  logic       i_power_on;
  logic       i_req_valid;
  logic [2:0] i_req_mode;
  logic       o_req_accept;
  logic       o_req_reject;
  logic [1:0] o_fan_level;
  logic       o_cleaning;
  logic [7:0] o_time_left;
  logic       o_hurr_avail;
  logic       o_clean_reminder;

  int n_cmp = 0;
  int n_bad = 0;

  hood_mode_sequencer #(
    .HURR_S   (60),
    .CLEAN_S  (180),
    .REMIND_S (5),
    .USAGE_W  (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_tick_1hz       (i_tick_1hz),
    .i_power_on       (i_power_on),
    .i_req_valid      (i_req_valid),
    .i_req_mode       (i_req_mode),
    .o_req_accept     (o_req_accept),
    .o_req_reject     (o_req_reject),
    .o_fan_level      (o_fan_level),
    .o_cleaning       (o_cleaning),
    .o_time_left      (o_time_left),
    .o_hurr_avail     (o_hurr_avail),
    .o_clean_reminder (o_clean_reminder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pwr;
    logic       vld;
    logic [2:0] mode;
    logic       tick;
    logic       acc;
    logic       rej;
    logic [1:0] fan;
    logic [7:0] tl;
    logic       hurr;
  } vec_t;

  function automatic vec_t mk(input logic pwr, input logic vld, input logic [2:0] mode,
                              input logic tick, input logic acc, input logic rej,
                              input logic [1:0] fan, input logic [7:0] tl, input logic hurr);
    vec_t v;
    v.pwr = pwr; v.vld = vld; v.mode = mode; v.tick = tick;
    v.acc = acc; v.rej = rej; v.fan = fan; v.tl = tl; v.hurr = hurr;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus, then compare the registered result.
  task automatic apply(input vec_t v, input string name);
    i_power_on  = v.pwr;
    i_req_valid = v.vld;
    i_req_mode  = v.mode;
    i_tick_1hz  = v.tick;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_tick_1hz  = 1'b0;
    check({name, ".accept"}, int'(o_req_accept), int'(v.acc));
    check({name, ".reject"}, int'(o_req_reject), int'(v.rej));
    check({name, ".fan"},    int'(o_fan_level),  int'(v.fan));
    check({name, ".tleft"},  int'(o_time_left),  int'(v.tl));
    check({name, ".hurr"},   int'(o_hurr_avail), int'(v.hurr));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_tick_1hz = 1'b1;
      @(posedge clk);
      #1;
      i_tick_1hz = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = mk(1, 1, 3'd2, 0, 1, 0, 2, 0,  1);  // OFF -> L2
    tbl[1] = mk(1, 1, 3'd1, 0, 1, 0, 1, 0,  1);  // L2 -> L1
    tbl[2] = mk(1, 1, 3'd1, 0, 1, 0, 1, 0,  1);  // same state, no-op accept
    tbl[3] = mk(1, 1, 3'd5, 0, 0, 1, 1, 0,  1);  // illegal mode
    tbl[4] = mk(1, 1, 3'd7, 0, 0, 1, 1, 0,  1);  // illegal mode
    tbl[5] = mk(0, 1, 3'd2, 0, 0, 1, 0, 0,  1);  // request while powered off
    tbl[6] = mk(1, 0, 3'd0, 0, 0, 0, 0, 0,  1);  // re-power, idle
    tbl[7] = mk(1, 1, 3'd1, 0, 1, 0, 1, 0,  1);  // OFF -> L1
    tbl[8] = mk(1, 1, 3'd3, 1, 1, 0, 3, 60, 0);  // HURR with tick in load cycle
    tbl[9] = mk(1, 0, 3'd0, 0, 0, 0, 3, 60, 0);  // idle in HURR

    i_tick_1hz  = 1'b0;
    i_power_on  = 1'b0;
    i_req_valid = 1'b0;
    i_req_mode  = 3'd0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.accept",   int'(o_req_accept),     0);
    check("reset.reject",   int'(o_req_reject),     0);
    check("reset.fan",      int'(o_fan_level),      0);
    check("reset.cleaning", int'(o_cleaning),       0);
    check("reset.tleft",    int'(o_time_left),      0);
    check("reset.hurr",     int'(o_hurr_avail),     1);
    check("reset.remind",   int'(o_clean_reminder), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Hurricane runs down to L2; an OFF request on the expiry tick is refused.
    ticks(59);
    check("hurr59.tleft", int'(o_time_left), 1);
    check("hurr59.fan",   int'(o_fan_level), 3);
    apply(mk(1, 1, 3'd0, 1, 0, 1, 2, 0, 0), "hurr_expire_req");
    apply(mk(1, 1, 3'd3, 0, 0, 1, 2, 0, 0), "hurr_second");
    apply(mk(1, 1, 3'd1, 0, 1, 0, 1, 0, 0), "to_l1");

    // Off-pending hurricane ends in OFF.
    apply(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 1), "pwr_cycle_a");
    apply(mk(1, 1, 3'd3, 0, 1, 0, 3, 60, 0), "hurr_b");
    ticks(40);
    apply(mk(1, 1, 3'd0, 0, 1, 0, 3, 20, 0), "hurr_off_req");
    apply(mk(1, 1, 3'd1, 0, 0, 1, 3, 20, 0), "hurr_l1_req");
    apply(mk(1, 1, 3'd3, 0, 0, 1, 3, 20, 0), "hurr_hurr_req");
    ticks(19);
    check("hurr_b19.tleft", int'(o_time_left), 1);
    apply(mk(1, 0, 3'd0, 1, 0, 0, 0, 0, 0), "hurr_b_expire");

    // Self-clean from OFF; clears the accumulated usage on completion.
    check("pre_clean.remind", int'(o_clean_reminder), 1);
    apply(mk(1, 1, 3'd4, 0, 1, 0, 0, 180, 0), "clean_start");
    check("clean.cleaning", int'(o_cleaning), 1);
    apply(mk(1, 1, 3'd1, 0, 0, 1, 0, 180, 0), "clean_l1_req");
    apply(mk(1, 1, 3'd0, 0, 0, 1, 0, 180, 0), "clean_off_req");
    apply(mk(1, 1, 3'd4, 0, 0, 1, 0, 180, 0), "clean_clean_req");
    ticks(179);
    check("clean179.tleft",    int'(o_time_left),      1);
    check("clean179.cleaning", int'(o_cleaning),       1);
    check("clean179.remind",   int'(o_clean_reminder), 1);
    apply(mk(1, 1, 3'd2, 1, 0, 1, 0, 0, 0), "clean_expire_req");
    check("clean_done.cleaning", int'(o_cleaning),       0);
    check("clean_done.remind",   int'(o_clean_reminder), 0);

    // Reminder after five fan-on seconds.
    apply(mk(1, 1, 3'd1, 0, 1, 0, 1, 0, 0), "remind_l1");
    ticks(4);
    check("remind4", int'(o_clean_reminder), 0);
    ticks(1);
    check("remind5", int'(o_clean_reminder), 1);

    // Power loss mid-hurricane starts a new session.
    apply(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 1), "pwr_cycle_c");
    apply(mk(1, 1, 3'd3, 0, 1, 0, 3, 60, 0), "hurr_c");
    ticks(30);
    check("hurr_c30.tleft", int'(o_time_left), 30);
    apply(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 1), "hurr_c_abort");
    apply(mk(1, 1, 3'd3, 0, 1, 0, 3, 60, 0), "hurr_d");

    // Aborted clean leaves usage intact.
    apply(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 1), "pwr_cycle_e");
    apply(mk(1, 1, 3'd4, 0, 1, 0, 0, 180, 1), "clean_e");
    ticks(3);
    apply(mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 1), "clean_e_abort");
    check("clean_e_abort.cleaning", int'(o_cleaning),       0);
    check("clean_e_abort.remind",   int'(o_clean_reminder), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
